// File: rtl/triangle_emitter.sv
// Producer side of the triangle FIFO: fetches index triples, gathers each vertex's
// attribute words and queues them through a two-entry skid buffer into the FIFO.
module triangle_emitter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int INDEX_WIDTH    = 8,
    parameter int IDX_ADDR_WIDTH = 10
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [IDX_ADDR_WIDTH-1:0]         triCount,
    input  logic [ADDR_WIDTH-1:0]             vertexSize,
    output logic                              busy,
    output logic                              done,
    output logic                              idx_rd_en,
    output logic [IDX_ADDR_WIDTH-1:0]         idx_rd_addr,
    input  logic [INDEX_WIDTH-1:0]            idx_rd_data,
    output logic                              vert_rd_en,
    output logic [INDEX_WIDTH+ADDR_WIDTH-1:0] vert_rd_addr,
    input  logic [DATA_WIDTH-1:0]             vert_rd_data,
    output logic [DATA_WIDTH-1:0]             tri_fifo_wr_data,
    output logic                              tri_fifo_wr_en,
    input  logic                              tri_fifo_full,
    output logic [IDX_ADDR_WIDTH-1:0]         tris_emitted
);

    typedef enum logic [1:0] {IDLE, FETCH_IDX, EMIT, DRAIN} state_t;

    state_t                      state;
    logic [IDX_ADDR_WIDTH-1:0]   tri_count_reg;
    logic [IDX_ADDR_WIDTH-1:0]   idx_ptr;
    logic [IDX_ADDR_WIDTH-1:0]   tri_cnt;
    logic [IDX_ADDR_WIDTH-1:0]   next_tri;
    logic [ADDR_WIDTH-1:0]       vsize_reg;
    logic [ADDR_WIDTH-1:0]       word_cnt;
    logic [1:0]                  fetch_cnt;
    logic [1:0]                  vert_cnt;
    logic [INDEX_WIDTH-1:0]      idx0, idx1, idx2;
    logic [INDEX_WIDTH-1:0]      cur_idx;
    logic                        rd_vld_p1;
    logic [1:0]                  skid_count;
    logic [1:0]                  occupancy;
    logic [DATA_WIDTH-1:0]       skid_head, skid_tail;
    logic                        pop;
    logic                        can_issue;

    // Occupancy the skid buffer will have after this cycle's pop and returning word;
    // a new read is only safe if that leaves room for the word it brings back.
    assign pop       = (skid_count != 2'd0) && !tri_fifo_full;
    assign occupancy = skid_count - {1'b0, pop} + {1'b0, rd_vld_p1};
    assign can_issue = (state == EMIT) && (occupancy < 2'd2);
    assign next_tri  = tri_cnt + 1'b1;

    always_comb begin
        case (vert_cnt)
            2'd0:    cur_idx = idx0;
            2'd1:    cur_idx = idx1;
            default: cur_idx = idx2;
        endcase
    end

    assign busy             = (state != IDLE);
    assign done             = (state == DRAIN) && !rd_vld_p1 && (skid_count == 2'd0);
    assign idx_rd_en        = (state == FETCH_IDX) && (fetch_cnt != 2'd3);
    assign idx_rd_addr      = idx_rd_en ? idx_ptr : '0;
    assign vert_rd_en       = can_issue;
    assign vert_rd_addr     = can_issue ? {cur_idx, word_cnt} : '0;
    assign tri_fifo_wr_en   = pop;
    assign tri_fifo_wr_data = pop ? skid_head : '0;
    assign tris_emitted     = tri_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            tri_count_reg <= '0;
            vsize_reg     <= '0;
            idx_ptr       <= '0;
            tri_cnt       <= '0;
            word_cnt      <= '0;
            fetch_cnt     <= 2'd0;
            vert_cnt      <= 2'd0;
            rd_vld_p1     <= 1'b0;
            skid_count    <= 2'd0;
        end else begin
            rd_vld_p1  <= can_issue;
            skid_count <= occupancy;
            case (state)
                IDLE: begin
                    if (start) begin
                        tri_count_reg <= triCount;
                        vsize_reg     <= vertexSize;
                        idx_ptr       <= '0;
                        tri_cnt       <= '0;
                        word_cnt      <= '0;
                        fetch_cnt     <= 2'd0;
                        vert_cnt      <= 2'd0;
                        state         <= (triCount == '0) ? DRAIN : FETCH_IDX;
                    end
                end
                FETCH_IDX: begin
                    if (fetch_cnt == 2'd3) begin
                        fetch_cnt <= 2'd0;
                        state     <= EMIT;
                    end else begin
                        fetch_cnt <= fetch_cnt + 2'd1;
                        idx_ptr   <= idx_ptr + 1'b1;
                    end
                end
                EMIT: begin
                    if (can_issue) begin
                        if (word_cnt == vsize_reg) begin
                            word_cnt <= '0;
                            if (vert_cnt == 2'd2) begin
                                vert_cnt <= 2'd0;
                                tri_cnt  <= next_tri;
                                state    <= (next_tri < tri_count_reg) ? FETCH_IDX : DRAIN;
                            end else begin
                                vert_cnt <= vert_cnt + 2'd1;
                            end
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    if (done) state <= IDLE;
                end
            endcase
        end
    end

    // Index data returns one cycle after each read; fetch_cnt 1..3 line up with i0..i2.
    always_ff @(posedge clk) begin
        if (state == FETCH_IDX) begin
            case (fetch_cnt)
                2'd1:    idx0 <= idx_rd_data;
                2'd2:    idx1 <= idx_rd_data;
                2'd3:    idx2 <= idx_rd_data;
                default: ;
            endcase
        end
    end

    // Skid buffer storage; a word arriving while full is only possible alongside a pop.
    always_ff @(posedge clk) begin
        if (rd_vld_p1) begin
            case (skid_count)
                2'd0: skid_head <= vert_rd_data;
                2'd1: begin
                    if (pop) skid_head <= vert_rd_data;
                    else     skid_tail <= vert_rd_data;
                end
                default: begin
                    skid_head <= skid_tail;
                    skid_tail <= vert_rd_data;
                end
            endcase
        end else if (pop) begin
            skid_head <= skid_tail;
        end
    end

endmodule

// File: doc/triangle_emitter.md
Name: triangle_emitter

Overview:
- Producer end of the triangle FIFO: the consumer drains 3 × (vertexSize+1) words per triangle into the per-vertex attribute memories.
- Reads index triples from an index memory, gathers each referenced vertex's attribute words from the post-transform vertex memory, and pushes them into the FIFO in the order the consumer expects.
- Sits between vertex processing and the triangle pipe's fetch stage.

Parameters:
DATA_WIDTH, 32, FIFO / attribute word width
ADDR_WIDTH, 4, per-vertex word offset width (max vertexSize)
INDEX_WIDTH, 8, vertex index width
IDX_ADDR_WIDTH, 10, index memory address width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  pulse: begin emitting a batch
triCount  in  IDX_ADDR_WIDTH  triangles in batch, sampled on start
vertexSize  in  ADDR_WIDTH  last word offset per vertex (vertex = vertexSize+1 words), sampled on start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when batch fully written to FIFO
idx_rd_en  out  1  index memory read strobe
idx_rd_addr  out  IDX_ADDR_WIDTH  index memory address
idx_rd_data  in  INDEX_WIDTH  index data, valid cycle after idx_rd_en
vert_rd_en  out  1  vertex memory read strobe
vert_rd_addr  out  INDEX_WIDTH+ADDR_WIDTH  {index, word offset}
vert_rd_data  in  DATA_WIDTH  vertex word, valid cycle after vert_rd_en
tri_fifo_wr_data  out  DATA_WIDTH  FIFO write data
tri_fifo_wr_en  out  1  FIFO push
tri_fifo_full  in  1  FIFO full, no push allowed
tris_emitted  out  IDX_ADDR_WIDTH  triangles fully queued in current batch

Behaviour:
- Reset: state IDLE; all outputs 0; skid buffer empty; idx pointer 0; tris_emitted 0.
- FSM states:
  - IDLE: on start, latch triCount and vertexSize, clear idx pointer and tris_emitted, set busy.
    - triCount==0 → DRAIN.
    - Otherwise → FETCH_IDX.
    - start while busy is ignored.
  - FETCH_IDX: 3 consecutive reads at idx pointer, pointer+1, pointer+2.
    - Pointer increments by 1 per read and wraps modulo 2^IDX_ADDR_WIDTH.
    - Returned data captured as i0, i1, i2 one cycle after each read.
    - → EMIT the cycle after i2 is captured (4 cycles total).
  - EMIT: word order is vertex v=0,1,2; for each vertex, word w=0..vertexSizeReg.
    - vert_rd_addr = {i_v, w}.
    - Words 0/1 are position high/low, as the consumer requires.
    - A read is issued only when (skid_count − drain_this_cycle + inflight) < 2; inflight ≤1 given 1-cycle latency.
    - After the last word of v=2 is issued: tris_emitted+1.
    - Then → FETCH_IDX if tris_emitted+1 < triCountReg, else → DRAIN.
    - Index prefetch for the next triangle may overlap the final reads.
  - DRAIN: wait until inflight==0 and skid empty; pulse done, clear busy, → IDLE.
- Skid buffer: 2-entry FIFO holding returned vert_rd_data.
  - Each returning word enters the tail.
  - tri_fifo_wr_en = skid nonempty && !tri_fifo_full (combinational on full); tri_fifo_wr_data = skid head.
  - Head pops on each push.
  - Push and fill in the same cycle is legal; count unchanged.
- Throughput: 1 word/cycle while FIFO not full. Per-triangle overhead ≤4 cycles for index fetch.
- Backpressure: tri_fifo_full high for any number of cycles:
  - no push;
  - at most 2 words held;
  - no word lost, reordered, or duplicated;
  - resumes the cycle full drops.
- No partial triangles: words are always contiguous 3×(vertexSize+1) blocks per triangle.
- vertexSize=0 is legal: 1 word per vertex, 3 words per triangle.
- Reset asserted mid-batch:
  - next edge returns to reset state;
  - tri_fifo_wr_en low in that cycle;
  - in-flight read data is discarded;
  - no done pulse.
- vertexSize and triCount changes during a batch have no effect (registered copies only).

Test Plan:
- triCount=1, vertexSize=3, indices {2,5,7}, vertex word = {idx,w} → 12 pushes in order 0x20,21,22,23,0x50..53,0x70..73; done 1 cycle after last push; tris_emitted=1.
- triCount=4, vertexSize=7, FIFO never full → 96 pushes; consecutive within each triangle; ≤4 idle cycles between triangles; done pulses once.
- Same as previous, tri_fifo_full toggled randomly (30%) → identical 96-word sequence; never wr_en while full.
- Full held 20 cycles mid-vertex → ≤2 reads outstanding; output resumes the cycle full drops with no gap or loss.
- triCount=0 → no reads, no pushes; done within 2 cycles; start during busy ignored.
- reset asserted at word 5 of triangle 2 → next cycle all outputs 0; a new start gives a clean batch from idx address 0.
